// File: rtl/lvds_pkg.sv
// LVDS panel power sequencer: shared state encoding
// and default panel timing constants.
package lvds_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_VDD_ON   = 3'd1,
    ST_LINK_ON  = 3'd2,
    ST_RUN      = 3'd3,
    ST_BL_OFF   = 3'd4,
    ST_LINK_OFF = 3'd5,
    ST_COOLDOWN = 3'd6
  } lvds_state_e;

  localparam int DEF_CLK_KHZ = 51429;
  localparam int DEF_T2_MS   = 20;
  localparam int DEF_T3_MS   = 250;
  localparam int DEF_T4_MS   = 250;
  localparam int DEF_T5_MS   = 20;
  localparam int DEF_T7_MS   = 1000;

  localparam int MS_W = 16;

endpackage

// File: rtl/lvds_power_seq_if.sv
// Panel control bundle between a host and the
// power sequencer: request/lock in, rail enables out.
interface lvds_power_seq_if;
  import lvds_pkg::*;

  logic       enable;
  logic       pll_lock;
  logic       vdd_en;
  logic       lvds_resetn;
  logic       bl_en;
  logic       ready;
  logic [2:0] state;

  modport master (
    output enable,
    output pll_lock,
    input  vdd_en,
    input  lvds_resetn,
    input  bl_en,
    input  ready,
    input  state
  );

  modport slave (
    input  enable,
    input  pll_lock,
    output vdd_en,
    output lvds_resetn,
    output bl_en,
    output ready,
    output state
  );

endinterface

// File: rtl/lvds_ms_timer.sv
// Millisecond dwell timer: prescaler plus ms counter,
// cleared on restart; expired flags the last cycle.
module lvds_ms_timer
  import lvds_pkg::*;
#(
  parameter int CLK_KHZ = DEF_CLK_KHZ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic [MS_W-1:0] target_ms,
  output logic            expired
);

  localparam int PW =
    (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(CLK_KHZ - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [MS_W-1:0] ms_q, ms_d;

  always_comb begin
    pre_d = pre_q + 1'b1;
    ms_d  = ms_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      ms_d  = ms_q + 1'b1;
    end
    if (restart) begin
      pre_d = '0;
      ms_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else begin
      pre_q <= pre_d;
      ms_q  <= ms_d;
    end
  end

  // High in the cycle before the exit edge, so the
  // dwell is exactly target*CLK_KHZ cycles (min 1).
  always_comb begin
    expired = (target_ms == '0) ||
              ((ms_q == target_ms - 1'b1) &&
               (pre_q == PRE_MAX));
  end

endmodule

// File: rtl/lvds_power_seq.sv
// LVDS panel power sequencer: VDD, link and backlight
// ordering with timed dwells and drop handling.
module lvds_power_seq
  import lvds_pkg::*;
#(
  parameter int CLK_KHZ = DEF_CLK_KHZ,
  parameter int T2_MS   = DEF_T2_MS,
  parameter int T3_MS   = DEF_T3_MS,
  parameter int T4_MS   = DEF_T4_MS,
  parameter int T5_MS   = DEF_T5_MS,
  parameter int T7_MS   = DEF_T7_MS
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_pll_lock,
  output logic       o_vdd_en,
  output logic       o_lvds_resetn,
  output logic       o_bl_en,
  output logic       o_ready,
  output logic [2:0] o_state
);

  lvds_state_e     state_q, state_d;
  logic            vdd_en_q, vdd_en_d;
  logic            resetn_q, resetn_d;
  logic            bl_en_q, bl_en_d;
  logic            ready_q, ready_d;
  logic            drop;
  logic            expired;
  logic            restart;
  logic [MS_W-1:0] target_ms;

  assign drop = !i_enable || !i_pll_lock;

  always_comb begin
    target_ms = '0;
    unique case (state_q)
      ST_VDD_ON:   target_ms = MS_W'(T2_MS);
      ST_LINK_ON:  target_ms = MS_W'(T3_MS);
      ST_BL_OFF:   target_ms = MS_W'(T4_MS);
      ST_LINK_OFF: target_ms = MS_W'(T5_MS);
      ST_COOLDOWN: target_ms = MS_W'(T7_MS);
      default:     target_ms = '0;
    endcase
  end

  // Drop is checked first so it wins over expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:
        if (!drop) state_d = ST_VDD_ON;
      ST_VDD_ON:
        if (drop)         state_d = ST_COOLDOWN;
        else if (expired) state_d = ST_LINK_ON;
      ST_LINK_ON:
        if (drop)         state_d = ST_LINK_OFF;
        else if (expired) state_d = ST_RUN;
      ST_RUN:
        if (drop) state_d = ST_BL_OFF;
      ST_BL_OFF:
        if (expired) state_d = ST_LINK_OFF;
      ST_LINK_OFF:
        if (expired) state_d = ST_COOLDOWN;
      ST_COOLDOWN:
        if (expired) state_d = ST_OFF;
      default:
        state_d = ST_OFF;
    endcase
  end

  always_comb begin
    vdd_en_d = (state_d != ST_OFF) &&
               (state_d != ST_COOLDOWN);
    resetn_d = (state_d == ST_LINK_ON) ||
               (state_d == ST_RUN) ||
               (state_d == ST_BL_OFF);
    bl_en_d  = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_OFF;
      vdd_en_q <= 1'b0;
      resetn_q <= 1'b0;
      bl_en_q  <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vdd_en_q <= vdd_en_d;
      resetn_q <= resetn_d;
      bl_en_q  <= bl_en_d;
      ready_q  <= ready_d;
    end
  end

  lvds_ms_timer #(
    .CLK_KHZ(CLK_KHZ)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_reset),
    .restart  (restart),
    .target_ms(target_ms),
    .expired  (expired)
  );

  assign o_vdd_en      = vdd_en_q;
  assign o_lvds_resetn = resetn_q;
  assign o_bl_en       = bl_en_q;
  assign o_ready       = ready_q;
  assign o_state       = state_q;

endmodule
